// File: rtl/uart_alici_pkg.sv
// Shared constants and FSM state codes for the uart_alici receiver.
`timescale 1ns/1ps
package uart_alici_pkg;

   localparam int UART_VERI_BIT = 8;
   localparam int UART_MIN_DIV  = 4;

   typedef enum logic [2:0] {
      ALICI_BOSTA,
      ALICI_BASLA,
      ALICI_VERI,
      ALICI_DUR,
      ALICI_BEKLE
   } alici_durum_e;

endpackage

// File: rtl/uart_alici_senkronlayici.sv
// Multi-flop synchronizer for a single asynchronous input, with a
// configurable reset value so idle-high lines come out of reset idle.
`timescale 1ns/1ps
module uart_alici_senkronlayici #(
   parameter int   KADEME       = 2,
   parameter logic RESET_DEGERI = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic giris,
   output logic cikis
);

   logic [KADEME-1:0] zincir;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) zincir <= {KADEME{RESET_DEGERI}};
      else        zincir <= {zincir[KADEME-2:0], giris};
   end

   assign cikis = zincir[KADEME-1];

endmodule

// File: rtl/uart_alici.sv
// 8N1 UART receiver: mid-bit sampling of the synchronized rx line, byte
// delivery over valid/ready, framing-error and overrun pulses.
`timescale 1ns/1ps
module uart_alici
   import uart_alici_pkg::*;
#(
   parameter int SENK_KADEME = 2,
   parameter int VERI_BIT    = UART_VERI_BIT
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                rx,
   input  logic [15:0]         baud_div_i,
   output logic [VERI_BIT-1:0] veri_o,
   output logic                veri_gecerli_o,
   input  logic                veri_hazir_i,
   output logic                cerceve_hatasi_o,
   output logic                tasma_o
);

   localparam int IDX_W = $clog2(VERI_BIT);
   localparam logic [IDX_W-1:0] SON_IDX = IDX_W'(VERI_BIT - 1);

   logic                rx_s;
   alici_durum_e        durum;
   logic [15:0]         sayac;
   logic [15:0]         div_r;
   logic [IDX_W-1:0]    idx;
   logic [VERI_BIT-1:0] kaydirma;
   logic [15:0]         yarim_son;
   logic [15:0]         bit_son;

   uart_alici_senkronlayici #(
      .KADEME       (SENK_KADEME),
      .RESET_DEGERI (1'b1)
   ) u_senk (
      .clk   (clk_i),
      .rst_n (rstn_i),
      .giris (rx),
      .cikis (rx_s)
   );

   // Terminal counts come from the frame-frozen divisor, never the live input.
   assign yarim_son = (div_r >> 1) - 16'd1;
   assign bit_son   = div_r - 16'd1;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         durum            <= ALICI_BOSTA;
         sayac            <= '0;
         div_r            <= '0;
         idx              <= '0;
         kaydirma         <= '0;
         veri_o           <= '0;
         veri_gecerli_o   <= 1'b0;
         cerceve_hatasi_o <= 1'b0;
         tasma_o          <= 1'b0;
      end else begin
         // NOTE: pulses default low every cycle with <=; a later assignment
         // in this same block wins, which is how the one-cycle pulses form.
         cerceve_hatasi_o <= 1'b0;
         tasma_o          <= 1'b0;
         if (veri_gecerli_o && veri_hazir_i) veri_gecerli_o <= 1'b0;

         case (durum)
            ALICI_BOSTA: begin
               if (!rx_s && (baud_div_i >= 16'(UART_MIN_DIV))) begin
                  div_r <= baud_div_i;
                  sayac <= '0;
                  durum <= ALICI_BASLA;
               end
            end

            ALICI_BASLA: begin
               if (sayac == yarim_son) begin
                  if (!rx_s) begin
                     sayac <= '0;
                     idx   <= '0;
                     durum <= ALICI_VERI;
                  end else begin
                     durum <= ALICI_BOSTA;
                  end
               end else begin
                  sayac <= sayac + 16'd1;
               end
            end

            ALICI_VERI: begin
               if (sayac == bit_son) begin
                  kaydirma <= {rx_s, kaydirma[VERI_BIT-1:1]};
                  sayac    <= '0;
                  if (idx == SON_IDX) durum <= ALICI_DUR;
                  else                idx   <= idx + 1'b1;
               end else begin
                  sayac <= sayac + 16'd1;
               end
            end

            ALICI_DUR: begin
               if (sayac == bit_son) begin
                  sayac <= '0;
                  if (rx_s) begin
                     durum <= ALICI_BOSTA;
                     // A slot is free if empty or being drained this very cycle.
                     if (!veri_gecerli_o || veri_hazir_i) begin
                        veri_o         <= kaydirma;
                        veri_gecerli_o <= 1'b1;
                     end else begin
                        tasma_o <= 1'b1;
                     end
                  end else begin
                     cerceve_hatasi_o <= 1'b1;
                     durum            <= ALICI_BEKLE;
                  end
               end else begin
                  sayac <= sayac + 16'd1;
               end
            end

            ALICI_BEKLE: begin
               if (rx_s) durum <= ALICI_BOSTA;
            end

            default: durum <= ALICI_BOSTA;
         endcase
      end
   end

endmodule
